// File: rtl/frame_timing_pkg.sv
// Shared constants for the frame/slot/symbol timing block: sync-state codes,
// index widths, frame-number wrap and symbol-length clamping.
package frame_timing_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam int SLOT_W  = 5;
    localparam int SYM_W   = 4;
    localparam int SFN_W   = 10;
    localparam int SFN_MAX = 1023;

    // A zero-length symbol would never reach its end count; run it as one clock.
    function automatic int unsigned len_clamp(input int unsigned len);
        return (len == 0) ? 1 : len;
    endfunction

endpackage

// File: rtl/frame_sym_counter.sv
// Clock/symbol/slot counter chain with frame-latched symbol lengths.
// Flags the last clock of the frame and registers the boundary strobes.
module frame_sym_counter
    import frame_timing_pkg::*;
#(
    parameter int SLOT_NUM = 20,
    parameter int SYM_NUM  = 14,
    parameter int LEN_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              restart,
    input  logic              enable,
    input  logic [LEN_W-1:0]  sym_len_long,
    input  logic [LEN_W-1:0]  sym_len_norm,
    output logic              wrap,
    output logic              frame_start,
    output logic              slot_start,
    output logic              sym_start,
    output logic [SLOT_W-1:0] slot_idx,
    output logic [SYM_W-1:0]  sym_idx
);

    logic [LEN_W-1:0] clk_cnt;
    logic [LEN_W-1:0] long_sh;
    logic [LEN_W-1:0] norm_sh;
    logic [LEN_W-1:0] cur_len;
    logic             sym_end;
    logic             slot_end;

    // NOTE: every always_comb output is assigned unconditionally, so no latch can be inferred.
    always_comb begin
        cur_len  = (sym_idx == '0) ? long_sh : norm_sh;
        sym_end  = (clk_cnt == cur_len - LEN_W'(1));
        slot_end = sym_end && (sym_idx == SYM_W'(SYM_NUM - 1));
        wrap     = slot_end && (slot_idx == SLOT_W'(SLOT_NUM - 1));
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk_cnt     <= '0;
            sym_idx     <= '0;
            slot_idx    <= '0;
            long_sh     <= LEN_W'(1);
            norm_sh     <= LEN_W'(1);
            frame_start <= 1'b0;
            slot_start  <= 1'b0;
            sym_start   <= 1'b0;
        end else if (restart || (enable && wrap)) begin
            // Every frame start, forced or natural, picks up the current length config.
            clk_cnt     <= '0;
            sym_idx     <= '0;
            slot_idx    <= '0;
            long_sh     <= LEN_W'(len_clamp(32'(sym_len_long)));
            norm_sh     <= LEN_W'(len_clamp(32'(sym_len_norm)));
            frame_start <= 1'b1;
            slot_start  <= 1'b1;
            sym_start   <= 1'b1;
        end else if (enable) begin
            frame_start <= 1'b0;
            slot_start  <= slot_end;
            sym_start   <= sym_end;
            if (sym_end) begin
                clk_cnt <= '0;
                if (slot_end) begin
                    sym_idx  <= '0;
                    slot_idx <= slot_idx + SLOT_W'(1);
                end else begin
                    sym_idx <= sym_idx + SYM_W'(1);
                end
            end else begin
                clk_cnt <= clk_cnt + LEN_W'(1);
            end
        end else begin
            clk_cnt     <= '0;
            sym_idx     <= '0;
            slot_idx    <= '0;
            frame_start <= 1'b0;
            slot_start  <= 1'b0;
            sym_start   <= 1'b0;
        end
    end

endmodule

// File: rtl/frame_slot_scheduler.sv
// Frame timing scheduler: lock FSM (IDLE/RUN/HOLDOVER), miss counting and
// frame numbering on top of the symbol/slot counter chain.
module frame_slot_scheduler
    import frame_timing_pkg::*;
#(
    parameter int SLOT_NUM = 20,
    parameter int SYM_NUM  = 14,
    parameter int LEN_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_frame_head,
    input  logic [LEN_W-1:0]  i_sym_len_long,
    input  logic [LEN_W-1:0]  i_sym_len_norm,
    input  logic [3:0]        i_max_miss,
    output logic              o_frame_start,
    output logic              o_slot_start,
    output logic              o_sym_start,
    output logic [SLOT_W-1:0] o_slot_idx,
    output logic [SYM_W-1:0]  o_sym_idx,
    output logic [SFN_W-1:0]  o_frame_num,
    output logic [1:0]        o_sync_state,
    output logic              o_timing_valid,
    output logic              o_resync
);

    logic [1:0] state;
    logic [1:0] state_nx;
    logic [3:0] miss_cnt;
    logic [3:0] miss_nx;
    logic       restart;
    logic       resync_nx;
    logic       wrap;

    always_comb begin
        state_nx  = state;
        miss_nx   = miss_cnt;
        restart   = 1'b0;
        resync_nx = 1'b0;
        case (state)
            ST_RUN, ST_HOLD: begin
                if (i_frame_head) begin
                    // A head on the wrap cycle is aligned; anywhere else it re-anchors the frame.
                    state_nx  = ST_RUN;
                    miss_nx   = '0;
                    restart   = !wrap;
                    resync_nx = !wrap;
                end else if (wrap) begin
                    miss_nx = miss_cnt + 4'd1;
                    if ((state == ST_RUN) ? (i_max_miss == '0) : (miss_nx >= i_max_miss)) begin
                        state_nx = ST_IDLE;
                        miss_nx  = '0;
                    end else begin
                        state_nx = ST_HOLD;
                    end
                end
            end
            default: begin
                if (i_frame_head) begin
                    state_nx = ST_RUN;
                    miss_nx  = '0;
                    restart  = 1'b1;
                end
            end
        endcase
    end

    frame_sym_counter #(
        .SLOT_NUM (SLOT_NUM),
        .SYM_NUM  (SYM_NUM),
        .LEN_W    (LEN_W)
    ) u_counter (
        .clk          (clk),
        .rst_n        (rst_n),
        .restart      (restart),
        .enable       (state_nx != ST_IDLE),
        .sym_len_long (i_sym_len_long),
        .sym_len_norm (i_sym_len_norm),
        .wrap         (wrap),
        .frame_start  (o_frame_start),
        .slot_start   (o_slot_start),
        .sym_start    (o_sym_start),
        .slot_idx     (o_slot_idx),
        .sym_idx      (o_sym_idx)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            miss_cnt       <= '0;
            o_frame_num    <= '0;
            o_timing_valid <= 1'b0;
            o_resync       <= 1'b0;
        end else begin
            state          <= state_nx;
            miss_cnt       <= miss_nx;
            o_timing_valid <= (state_nx != ST_IDLE);
            o_resync       <= resync_nx;
            // Only a head seen while locked advances the number; holdover wraps hold it.
            if (state == ST_IDLE || state_nx == ST_IDLE) begin
                o_frame_num <= '0;
            end else if (i_frame_head) begin
                o_frame_num <= (o_frame_num == SFN_W'(SFN_MAX)) ? '0 : o_frame_num + SFN_W'(1);
            end
        end
    end

    assign o_sync_state = state;

endmodule

// File: tb/tb_frame_slot_scheduler.sv
// Self-checking bench for frame_slot_scheduler: directed phases plus random
// heads/config/reset, compared each cycle against a position-in-frame model.
module tb_frame_slot_scheduler;

    localparam int SLOT_NUM = 2;
    localparam int SYM_NUM  = 14;
    localparam int LEN_W    = 16;
    localparam int SFN_MAX  = 1023;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             head;
    logic [LEN_W-1:0] len_long;
    logic [LEN_W-1:0] len_norm;
    logic [3:0]       max_miss;
    logic             frame_start, slot_start, sym_start, timing_valid, resync;
    logic [4:0]       slot_idx;
    logic [3:0]       sym_idx;
    logic [9:0]       frame_num;
    logic [1:0]       sync_state;

    always #5 clk = ~clk;

    frame_slot_scheduler #(
        .SLOT_NUM (SLOT_NUM),
        .SYM_NUM  (SYM_NUM),
        .LEN_W    (LEN_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_frame_head   (head),
        .i_sym_len_long (len_long),
        .i_sym_len_norm (len_norm),
        .i_max_miss     (max_miss),
        .o_frame_start  (frame_start),
        .o_slot_start   (slot_start),
        .o_sym_start    (sym_start),
        .o_slot_idx     (slot_idx),
        .o_sym_idx      (sym_idx),
        .o_frame_num    (frame_num),
        .o_sync_state   (sync_state),
        .o_timing_valid (timing_valid),
        .o_resync       (resync)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: frame position in clocks plus lock bookkeeping.
    int m_state = 0, m_pos = 0, m_long = 1, m_norm = 1, m_miss = 0, m_fnum = 0;
    int m_resync = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    function automatic int frame_len();
        return SLOT_NUM * (m_long + (SYM_NUM - 1) * m_norm);
    endfunction

    function automatic bit model_at_w();
        return (m_state != 0) && (m_pos == frame_len() - 1);
    endfunction

    task automatic model_edge();
        bit at_w;
        bit new_frame;
        at_w      = model_at_w();
        new_frame = 0;
        m_resync  = 0;
        if (!rst_n) begin
            m_state = 0; m_pos = 0; m_miss = 0; m_fnum = 0;
        end else if (m_state == 0) begin
            if (head) begin
                m_state = 1; m_fnum = 0; m_miss = 0; new_frame = 1;
            end
        end else if (head) begin
            m_resync  = at_w ? 0 : 1;
            m_state   = 1;
            m_miss    = 0;
            m_fnum    = (m_fnum + 1) % (SFN_MAX + 1);
            new_frame = 1;
        end else if (at_w) begin
            m_miss++;
            if ((m_state == 1 && max_miss == 0) || (m_state == 2 && m_miss >= int'(max_miss))) begin
                m_state = 0; m_miss = 0; m_fnum = 0; m_pos = 0;
            end else begin
                m_state = 2; new_frame = 1;
            end
        end else begin
            m_pos++;
        end
        if (new_frame) begin
            m_pos  = 0;
            m_long = (len_long == 0) ? 1 : int'(len_long);
            m_norm = (len_norm == 0) ? 1 : int'(len_norm);
        end
    endtask

    task automatic compare_all();
        int slen, r, e_slot, e_sym, e_fs, e_ss, e_ys;
        slen = m_long + (SYM_NUM - 1) * m_norm;
        e_slot = 0; e_sym = 0; e_fs = 0; e_ss = 0; e_ys = 0;
        if (m_state != 0) begin
            e_slot = m_pos / slen;
            r      = m_pos % slen;
            e_sym  = (r < m_long) ? 0 : 1 + (r - m_long) / m_norm;
            e_fs   = (m_pos == 0) ? 1 : 0;
            e_ss   = (r == 0) ? 1 : 0;
            e_ys   = (r == 0 || (r >= m_long && (r - m_long) % m_norm == 0)) ? 1 : 0;
        end
        check("frame_start", 32'(frame_start), 32'(e_fs));
        check("slot_start", 32'(slot_start), 32'(e_ss));
        check("sym_start", 32'(sym_start), 32'(e_ys));
        check("slot_idx", 32'(slot_idx), 32'(e_slot));
        check("sym_idx", 32'(sym_idx), 32'(e_sym));
        check("frame_num", 32'(frame_num), 32'(m_fnum));
        check("sync_state", 32'(sync_state), 32'(m_state));
        check("timing_valid", 32'(timing_valid), 32'(m_state != 0));
        check("resync", 32'(resync), 32'(m_resync));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc++;
        compare_all();
    endtask

    task automatic run_aligned(input int n);
        for (int i = 0; i < n; i++) begin
            head = model_at_w();
            step();
        end
        head = 1'b0;
    endtask

    initial begin
        int slot_t[$];
        int sym_t[$];
        int t0, heads;
        rst_n = 1'b0; head = 1'b0; len_long = 16'd6; len_norm = 16'd4; max_miss = 4'd3;

        // Reset state
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Lock on a head, check slot and symbol spacing
        head = 1'b1;
        step();
        head = 1'b0;
        t0 = cyc;
        check("first_frame_start", 32'(frame_start), 32'd1);
        for (int i = 0; i < 120; i++) begin
            head = model_at_w();
            step();
            if (slot_start) slot_t.push_back(cyc);
            if (sym_start && sym_t.size() < 2) sym_t.push_back(cyc);
        end
        head = 1'b0;
        check("slot_spacing", 32'(slot_t[0] - t0), 32'd58);
        check("sym_gap_long", 32'(sym_t[0] - t0), 32'd6);
        check("sym_gap_norm", 32'(sym_t[1] - sym_t[0]), 32'd4);

        // Aligned heads over several frames, then an off-boundary head
        run_aligned(3 * 116);
        while (m_pos != 49 && cyc < 2000) step();
        head = 1'b1;
        step();
        head = 1'b0;
        check("resync_pulse", 32'(resync), 32'd1);
        check("resync_restart_idx", 32'(sym_idx), 32'd0);
        head = 1'b1;
        step();
        head = 1'b0;
        check("back_to_back_resync", 32'(resync), 32'd1);
        run_aligned(200);

        // Heads stop: holdover, then drop to IDLE after the third miss
        repeat (4 * 116 + 20) step();
        check("lost_lock_state", 32'(sync_state), 32'd0);
        check("lost_lock_valid", 32'(timing_valid), 32'd0);
        head = 1'b1;
        step();
        head = 1'b0;
        check("relock_frame_num", 32'(frame_num), 32'd0);

        // Mid-frame norm change applies from the next frame
        repeat (30) step();
        len_norm = 16'd5;
        run_aligned(116 + 142 + 10);

        // Zero tolerance: first miss drops lock directly
        max_miss = 4'd0;
        repeat (160) step();
        check("zero_tolerance_idle", 32'(sync_state), 32'd0);
        max_miss = 4'd3;

        // Reset mid-symbol
        head = 1'b1;
        step();
        head = 1'b0;
        repeat (9) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("mid_reset_valid", 32'(timing_valid), 32'd0);

        // Zero-length config: 1-clock symbols, 28-clock frames, frame number wrap
        len_long = '0; len_norm = '0;
        head = 1'b1;
        step();
        heads = 0;
        for (int i = 0; i < 40000 && heads < SFN_MAX + 1; i++) begin
            head = model_at_w();
            if (head) heads++;
            step();
        end
        head = 1'b0;
        check("sfn_wrap_start", 32'(frame_start), 32'd1);
        check("sfn_wrap_value", 32'(frame_num), 32'd0);

        // Random heads, config and resets
        for (int i = 0; i < 6000; i++) begin
            int r;
            r = int'($urandom_range(0, 999));
            rst_n = (r != 0);
            if (r < 10) begin
                len_long = LEN_W'($urandom_range(0, 7));
                len_norm = LEN_W'($urandom_range(0, 7));
            end
            if (r >= 10 && r < 15) max_miss = 4'($urandom_range(0, 3));
            head = model_at_w() ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 299) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
